// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment scanner.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] SEL_OFF = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StShow
  } state_e;

endpackage

// File: rtl/seg7_scan_hex2seg7.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex2seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  // Table lookup of the glyph for one hex digit.
  always_comb begin
    pattern = SEG_OFF;
    unique case (nibble)
      4'h0: pattern = SEG_HEX_0;
      4'h1: pattern = SEG_HEX_1;
      4'h2: pattern = SEG_HEX_2;
      4'h3: pattern = SEG_HEX_3;
      4'h4: pattern = SEG_HEX_4;
      4'h5: pattern = SEG_HEX_5;
      4'h6: pattern = SEG_HEX_6;
      4'h7: pattern = SEG_HEX_7;
      4'h8: pattern = SEG_HEX_8;
      4'h9: pattern = SEG_HEX_9;
      4'hA: pattern = SEG_HEX_A;
      4'hB: pattern = SEG_HEX_B;
      4'hC: pattern = SEG_HEX_C;
      4'hD: pattern = SEG_HEX_D;
      4'hE: pattern = SEG_HEX_E;
      4'hF: pattern = SEG_HEX_F;
      default: pattern = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment scanner. Each digit slot is DIV
// cycles: BLANK all-off cycles for ghost suppression, then DIV-BLANK cycles
// of display. Inputs are snapshotted once per frame so a frame never tears.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned DIV   = 100000,
  parameter int unsigned BLANK = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] data,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_in,
  output logic [7:0]  sel_seg,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned ShowLen = DIV - BLANK;
  localparam int unsigned CntW    = $clog2(DIV);

  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK - 1);
  localparam logic [CntW-1:0] ShowLast  = CntW'(ShowLen - 1);

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            load;

  logic [31:0]     data_q;
  logic [7:0]      den_q;
  logic [7:0]      dp_q;

  logic [6:0]      hex_pat;
  logic            slot_end;

  assign slot_end = (state_q == StShow) && (cnt_q == ShowLast);

  // Glyph of the snapshot nibble for the digit currently being scanned.
  hex2seg7 u_hex2seg7 (
    .nibble  (data_q[{idx_q, 2'b00} +: 4]),
    .pattern (hex_pat)
  );

  // Control registers: state, digit index, slot counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Frame snapshot; only written at frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      den_q  <= '0;
      dp_q   <= '0;
    end else if (load) begin
      data_q <= data;
      den_q  <= digit_en;
      dp_q   <= dp_in;
    end
  end

  // Next-state logic; en low always wins and returns to idle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    if (!en) begin
      state_d = StIdle;
      idx_d   = 3'd0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StBlank;
          idx_d   = 3'd0;
          cnt_d   = '0;
          load    = 1'b1;
        end
        StBlank: begin
          if (cnt_q == BlankLast) begin
            state_d = StShow;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StShow: begin
          if (slot_end) begin
            state_d = StBlank;
            cnt_d   = '0;
            idx_d   = idx_q + 3'd1;
            load    = (idx_q == 3'd7);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          idx_d   = 3'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decode registered state only, so reset blanks them at once.
  // frame_done deliberately ignores en to keep inputs off the output paths.
  always_comb begin
    sel_seg    = SEL_OFF;
    seg        = SEG_OFF;
    dp         = 1'b1;
    frame_done = slot_end && (idx_q == 3'd7);
    if (state_q == StShow && den_q[idx_q]) begin
      sel_seg = ~(8'b1 << idx_q);
      seg     = hex_pat;
      dp      = ~dp_q[idx_q];
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with DIV=10, BLANK=2.
module tb_seg7_scan;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] data;
  logic [7:0]  digit_en;
  logic [7:0]  dp_in;
  logic [7:0]  sel_seg;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int checks;
  int failures;

  seg7_scan #(
    .DIV   (10),
    .BLANK (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .data       (data),
    .digit_en   (digit_en),
    .dp_in      (dp_in),
    .sel_seg    (sel_seg),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference glyphs, active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] ref_pat(input logic [3:0] n);
    case (n)
      4'h0: ref_pat = 7'b1000000;
      4'h1: ref_pat = 7'b1111001;
      4'h2: ref_pat = 7'b0100100;
      4'h3: ref_pat = 7'b0110000;
      4'h4: ref_pat = 7'b0011001;
      4'h5: ref_pat = 7'b0010010;
      4'h6: ref_pat = 7'b0000010;
      4'h7: ref_pat = 7'b1111000;
      4'h8: ref_pat = 7'b0000000;
      4'h9: ref_pat = 7'b0010000;
      4'hA: ref_pat = 7'b0001000;
      4'hB: ref_pat = 7'b0000011;
      4'hC: ref_pat = 7'b1000110;
      4'hD: ref_pat = 7'b0100001;
      4'hE: ref_pat = 7'b0000110;
      default: ref_pat = 7'b0001110;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int c, input logic [7:0] es,
                     input logic [6:0] eg, input logic ed, input logic ef);
    checks++;
    assert (sel_seg === es) else begin
      failures++;
      $error("FAIL %s.sel_seg cyc=%0d got=%h exp=%h", tag, c, sel_seg, es);
    end
    checks++;
    assert (seg === eg) else begin
      failures++;
      $error("FAIL %s.seg cyc=%0d got=%b exp=%b", tag, c, seg, eg);
    end
    checks++;
    assert (dp === ed) else begin
      failures++;
      $error("FAIL %s.dp cyc=%0d got=%b exp=%b", tag, c, dp, ed);
    end
    checks++;
    assert (frame_done === ef) else begin
      failures++;
      $error("FAIL %s.frame_done cyc=%0d got=%b exp=%b", tag, c, frame_done, ef);
    end
  endtask

  // Checks ncyc cycles of a frame starting at its first BLANK cycle.
  // At cycle chg_at the inputs are switched to the next frame's values.
  task automatic run_frame(input string tag, input int ncyc, input logic [31:0] d,
                           input logic [7:0] den, input logic [7:0] dpi, input int chg_at,
                           input logic [31:0] nd, input logic [7:0] nden,
                           input logic [7:0] ndp);
    for (int c = 0; c < ncyc; c++) begin
      int slot;
      int ph;
      slot = c / 10;
      ph   = c % 10;
      if (ph < 2 || !den[slot])
        chk(tag, c, 8'hFF, 7'h7F, 1'b1, c == 79);
      else
        chk(tag, c, ~(8'b1 << slot), ref_pat(d[slot*4 +: 4]), ~dpi[slot], c == 79);
      if (c == chg_at) begin
        data     = nd;
        digit_en = nden;
        dp_in    = ndp;
      end
      tick();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    data     = 32'h0;
    digit_en = 8'h00;
    dp_in    = 8'h00;

    #3;
    chk("reset", 0, 8'hFF, 7'h7F, 1'b1, 1'b0);

    data     = 32'h76543210;
    digit_en = 8'hFF;
    dp_in    = 8'h01;
    en       = 1'b1;
    #9;
    rst_n = 1'b1;
    chk("idle_after_release", 0, 8'hFF, 7'h7F, 1'b1, 1'b0);
    tick();

    // Frame 1: all digits, dp on digit 0; new inputs arrive in slot 3.
    run_frame("frame1", 80, 32'h76543210, 8'hFF, 8'h01,
              35, 32'hFEDCBA98, 8'hFD, 8'h01);
    // Frame 2: new snapshot, digit 1 masked off.
    run_frame("frame2", 80, 32'hFEDCBA98, 8'hFD, 8'h01,
              40, 32'h0F1E2D3C, 8'hFF, 8'h20);
    // Frame 3: stop partway into slot 5 SHOW.
    run_frame("frame3", 54, 32'h0F1E2D3C, 8'hFF, 8'h20,
              -1, 32'h0, 8'h00, 8'h00);
    chk("slot5_show", 54, 8'hDF, 7'b1111001, 1'b0, 1'b0);
    en = 1'b0;
    tick();
    chk("en_off_1", 55, 8'hFF, 7'h7F, 1'b1, 1'b0);
    tick();
    chk("en_off_2", 56, 8'hFF, 7'h7F, 1'b1, 1'b0);
    tick();
    chk("en_off_3", 57, 8'hFF, 7'h7F, 1'b1, 1'b0);

    // Restart with a fresh snapshot.
    data     = 32'h13579BDF;
    digit_en = 8'h7F;
    dp_in    = 8'h80;
    en       = 1'b1;
    tick();
    run_frame("restart", 25, 32'h13579BDF, 8'h7F, 8'h80,
              -1, 32'h0, 8'h00, 8'h00);
    chk("pre_async_rst", 25, 8'hFB, 7'b0000011, 1'b1, 1'b0);

    // Asynchronous reset between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 25, 8'hFF, 7'h7F, 1'b1, 1'b0);
    tick();
    chk("rst_held", 26, 8'hFF, 7'h7F, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
